// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Package  : trace_pkg
// Purpose  : Field widths, offsets and entry layout for the commit trace path.
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

  localparam int PC_W         = 32;
  localparam int IMM_W        = 32;
  localparam int REGN_W       = 5;
  localparam int TRACE_BASE_W = PC_W + IMM_W + 3 * REGN_W;

  // Bit offsets of each field inside the base record (pc in the MSBs)
  localparam int RDN_LSB  = 0;
  localparam int RS2N_LSB = RDN_LSB + REGN_W;
  localparam int RS1N_LSB = RS2N_LSB + REGN_W;
  localparam int IMM_LSB  = RS1N_LSB + REGN_W;
  localparam int PC_LSB   = IMM_LSB + IMM_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [IMM_W-1:0]  imm;
    logic [REGN_W-1:0] rs1n;
    logic [REGN_W-1:0] rs2n;
    logic [REGN_W-1:0] rdn;
  } trace_entry_t;

  function automatic trace_entry_t pack_entry(
    input logic [PC_W-1:0]   pc,
    input logic [IMM_W-1:0]  imm,
    input logic [REGN_W-1:0] rs1n,
    input logic [REGN_W-1:0] rs2n,
    input logic [REGN_W-1:0] rdn
  );
    trace_entry_t e;
    e.pc   = pc;
    e.imm  = imm;
    e.rs1n = rs1n;
    e.rs2n = rs2n;
    e.rdn  = rdn;
    return e;
  endfunction

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Purpose  : Synchronous FIFO with extra-MSB pointers, no read bypass, and an
//            overflow strobe for a push refused while full.
// Revision : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_en;
  logic             w_wr_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // A pop frees the head slot at the same edge, so a full FIFO still takes a push
  assign w_rd_en = pop && !w_empty;
  assign w_wr_en = push && (!w_full || w_rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
  end

  assign rdata    = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = push && !w_wr_en;

endmodule : trace_fifo
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_buffer
// Purpose  : Buffers retired-instruction records from write-back, keeps
//            cycle/retired/dropped counters and freezes capture on exception.
//            TRACE_CYCLE_STAMP_EN adds a cycle stamp in the trace_data MSBs.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
`ifdef TRACE_CYCLE_STAMP_EN
  localparam int TRACE_W = TRACE_BASE_W + CNT_W
`else
  localparam int TRACE_W = TRACE_BASE_W
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  input  logic [PC_W-1:0]    commit_pc,
  input  logic [IMM_W-1:0]   commit_imm,
  input  logic [REGN_W-1:0]  commit_rs1n,
  input  logic [REGN_W-1:0]  commit_rs2n,
  input  logic [REGN_W-1:0]  commit_rdn,
  input  logic               exception,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [TRACE_W-1:0] trace_data,
  output logic               trace_last,
  output logic               full,
  output logic               empty,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic [CNT_W-1:0]   dropped_cnt
);

  localparam int c_ENTRY_W = TRACE_W + 1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 r_halted;
  logic [CNT_W-1:0]     r_cycle_cnt;
  logic [CNT_W-1:0]     r_retired_cnt;
  logic [CNT_W-1:0]     r_dropped_cnt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_overflow;
  trace_entry_t         w_entry;
  logic [c_ENTRY_W-1:0] w_wdata;
  logic [c_ENTRY_W-1:0] w_rdata;

  assign w_push  = commit_valid && !r_halted;
  assign w_pop   = !w_empty && trace_ready;
  assign w_entry = pack_entry(commit_pc, commit_imm, commit_rs1n, commit_rs2n, commit_rdn);

  // The capture-cycle exception flag rides along as the entry LSB
`ifdef TRACE_CYCLE_STAMP_EN
  assign w_wdata = {r_cycle_cnt, w_entry, exception};
`else
  assign w_wdata = {w_entry, exception};
`endif

  trace_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .wdata    (w_wdata),
    .pop      (w_pop),
    .rdata    (w_rdata),
    .full     (w_full),
    .empty    (w_empty),
    .overflow (w_overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted      <= 1'b0;
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      r_dropped_cnt <= '0;
    end else begin
      if (!r_halted) begin
        r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
        if (exception) r_halted <= 1'b1;
      end
      if (w_push) r_retired_cnt <= r_retired_cnt + c_CNT_ONE;
      if (w_overflow && (r_dropped_cnt != '1)) r_dropped_cnt <= r_dropped_cnt + c_CNT_ONE;
    end
  end

  assign trace_valid = !w_empty;
  assign trace_data  = w_rdata[c_ENTRY_W-1:1];
  assign trace_last  = w_rdata[0];
  assign full        = w_full;
  assign empty       = w_empty;
  assign halted      = r_halted;
  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
  assign dropped_cnt = r_dropped_cnt;

endmodule : commit_trace_buffer
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_buffer
// Purpose  : Directed, table-driven self-checking bench for commit_trace_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;
  import trace_pkg::*;

`ifdef TRACE_CYCLE_STAMP_EN
  localparam int TW = TRACE_BASE_W + 32;
`else
  localparam int TW = TRACE_BASE_W;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          commit_valid = 1'b0;
  logic [31:0]   commit_pc = '0;
  logic [31:0]   commit_imm = '0;
  logic [4:0]    commit_rs1n = '0;
  logic [4:0]    commit_rs2n = '0;
  logic [4:0]    commit_rdn = '0;
  logic          exception = 1'b0;
  logic          trace_ready = 1'b0;
  logic          trace_valid;
  logic [TW-1:0] trace_data;
  logic          trace_last;
  logic          full;
  logic          empty;
  logic          halted;
  logic [31:0]   cycle_cnt;
  logic [31:0]   retired_cnt;
  logic [31:0]   dropped_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  commit_trace_buffer #(.DEPTH(16), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_imm   (commit_imm),
    .commit_rs1n  (commit_rs1n),
    .commit_rs2n  (commit_rs2n),
    .commit_rdn   (commit_rdn),
    .exception    (exception),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_data   (trace_data),
    .trace_last   (trace_last),
    .full         (full),
    .empty        (empty),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .retired_cnt  (retired_cnt),
    .dropped_cnt  (dropped_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ready;
    logic        exp_valid;
    logic [78:0] exp_base;
    logic        exp_empty;
    logic [31:0] exp_retired;
    logic [31:0] exp_cycle;
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic ready, input logic exp_valid, input logic [78:0] exp_base,
                              input logic exp_empty, input logic [31:0] exp_retired,
                              input logic [31:0] exp_cycle);
    vec_t v;
    v.cv = cv; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ready = ready;
    v.exp_valid = exp_valid; v.exp_base = exp_base; v.exp_empty = exp_empty;
    v.exp_retired = exp_retired; v.exp_cycle = exp_cycle;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [31:0] pc, input logic exc, input logic ready);
    commit_valid = cv;
    commit_pc    = pc;
    commit_imm   = pc ^ 32'hA5A5_0000;
    commit_rs1n  = 5'd1;
    commit_rs2n  = 5'd2;
    commit_rdn   = 5'd3;
    exception    = exc;
    trace_ready  = ready;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] head_pc();
    logic [78:0] b;
    b = trace_data[78:0];
    return b[PC_LSB +: PC_W];
  endfunction

  vec_t vecs[6];

  initial begin
    // pc, imm, rs1, rs2, rd packed MSB-first: {32'pc, 32'imm, 5, 5, 5}
    vecs[0] = mk(1, 32'h0, 32'h111, 5'd1, 5'd2, 5'd3, 1,
                 1, {32'h0, 32'h111, 5'd1, 5'd2, 5'd3}, 0, 32'd1, 32'd1);
    vecs[1] = mk(1, 32'h4, 32'h222, 5'd4, 5'd5, 5'd6, 1,
                 1, {32'h4, 32'h222, 5'd4, 5'd5, 5'd6}, 0, 32'd2, 32'd2);
    vecs[2] = mk(1, 32'h8, 32'h333, 5'd7, 5'd8, 5'd9, 1,
                 1, {32'h8, 32'h333, 5'd7, 5'd8, 5'd9}, 0, 32'd3, 32'd3);
    vecs[3] = mk(0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1,
                 0, 79'h0, 1, 32'd3, 32'd4);
    vecs[4] = mk(1, 32'hC, 32'h444, 5'd10, 5'd11, 5'd12, 0,
                 1, {32'hC, 32'h444, 5'd10, 5'd11, 5'd12}, 0, 32'd4, 32'd5);
    vecs[5] = mk(0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0,
                 1, {32'hC, 32'h444, 5'd10, 5'd11, 5'd12}, 0, 32'd4, 32'd6);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   trace_valid, 1'b0);
    check("rst_data",    trace_data, '0);
    check("rst_last",    trace_last, 1'b0);
    check("rst_full",    full, 1'b0);
    check("rst_empty",   empty, 1'b1);
    check("rst_halted",  halted, 1'b0);
    check("rst_cycle",   cycle_cnt, 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_dropped", dropped_cnt, 32'd0);

    // Table: in-order delivery with a ready consumer, then a held head
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      commit_valid = vecs[i].cv;
      commit_pc    = vecs[i].pc;
      commit_imm   = vecs[i].imm;
      commit_rs1n  = vecs[i].rs1;
      commit_rs2n  = vecs[i].rs2;
      commit_rdn   = vecs[i].rd;
      exception    = 1'b0;
      trace_ready  = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), trace_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      check($sformatf("vec%0d_retired", i), retired_cnt, vecs[i].exp_retired);
      check($sformatf("vec%0d_cycle", i), cycle_cnt, vecs[i].exp_cycle);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), trace_data[78:0], vecs[i].exp_base);
    end

    // Overflow: 20 commits with consumer stalled
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      step();
      if (i == 14) check("full_after15", full, 1'b0);
      if (i == 15) check("full_after16", full, 1'b1);
    end
    check("ovf_dropped", dropped_cnt, 32'd4);
    check("ovf_retired", retired_cnt, 32'd20);
    check("ovf_full",    full, 1'b1);
    check("ovf_head",    head_pc(), 32'h100);

    // Full FIFO with simultaneous push and pop
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    step();
    check("fp_full",    full, 1'b1);
    check("fp_dropped", dropped_cnt, 32'd4);
    check("fp_retired", retired_cnt, 32'd21);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d_valid", k), trace_valid, 1'b1);
      check($sformatf("drain%0d_pc", k), head_pc(), (k < 15) ? 32'h104 + 32'(4 * k) : 32'h200);
      step();
    end
    check("drain_empty", empty, 1'b1);

    // Exception freeze
    reset_dut();
    step();
    step();
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    step();
    check("exc_halted",  halted, 1'b1);
    check("exc_valid",   trace_valid, 1'b1);
    check("exc_last",    trace_last, 1'b1);
    check("exc_pc",      head_pc(), 32'h40);
    check("exc_retired", retired_cnt, 32'd1);
    check("exc_cycle",   cycle_cnt, 32'd3);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("hold%0d_cycle", k), cycle_cnt, 32'd3);
      check($sformatf("hold%0d_retired", k), retired_cnt, 32'd1);
    end
    trace_ready = 1'b1;
    step();
    check("exc_single_record", empty, 1'b1);
    check("exc_still_halted",  halted, 1'b1);

    // Asynchronous reset between edges with 5 entries queued
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), (i == 4), 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_arst_retired", retired_cnt, 32'd5);
    check("pre_arst_halted",  halted, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",   trace_valid, 1'b0);
    check("arst_empty",   empty, 1'b1);
    check("arst_data",    trace_data, '0);
    check("arst_halted",  halted, 1'b0);
    check("arst_cycle",   cycle_cnt, 32'd0);
    check("arst_retired", retired_cnt, 32'd0);
    check("arst_dropped", dropped_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef TRACE_CYCLE_STAMP_EN
    // Cycle stamps: capture while cycle_cnt reads 10 and 12
    reset_dut();
    repeat (10) step();
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h504, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("stamp0", trace_data[TW-1 -: 32], 32'd10);
    trace_ready = 1'b1;
    step();
    check("stamp1", trace_data[TW-1 -: 32], 32'd12);
    check("stamp1_pc", head_pc(), 32'h504);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_commit_trace_buffer
`default_nettype wire
